// File: rtl/wb_queue_stage_pkg.sv
// rtl/wb_queue_stage_pkg.sv - shared writeback types: source selector, load size, queue entry
package wb_queue_stage_pkg;

   localparam int unsigned XLEN_DEF       = 32;
   localparam int unsigned REG_ADDR_W_DEF = 5;

   typedef enum logic [2:0] {
      READ_ALU_RESULT = 3'd0,
      READ_MEM_RESULT = 3'd1,
      READ_REGFILE    = 3'd2,
      READ_PC4        = 3'd3,
      NO_WRITE_BACK   = 3'd4
   } write_back_mux_selector;

   typedef enum logic [2:0] {
      LOAD_B  = 3'd0,
      LOAD_H  = 3'd1,
      LOAD_W  = 3'd2,
      LOAD_BU = 3'd3,
      LOAD_HU = 3'd4
   } load_size_e;

   typedef struct packed {
      logic [REG_ADDR_W_DEF-1:0] rd;
      logic [XLEN_DEF-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - selects the addressed byte/halfword of a load word and extends it
module wb_load_align
   import wb_queue_stage_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] word,
   input  load_size_e      load_size,
   input  logic [1:0]      byte_offset,
   output logic [XLEN-1:0] data
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      lane_b = 8'h00;
      unique case (byte_offset)
         2'd0: lane_b = word[7:0];
         2'd1: lane_b = word[15:8];
         2'd2: lane_b = word[23:16];
         2'd3: lane_b = word[31:24];
      endcase
      // Halfword loads ignore offset bit 0; misalignment is trapped upstream.
      lane_h = byte_offset[1] ? word[31:16] : word[15:0];

      data = word;
      case (load_size)
         LOAD_B:  data = {{(XLEN-8){lane_b[7]}}, lane_b};
         LOAD_BU: data = {{(XLEN-8){1'b0}}, lane_b};
         LOAD_H:  data = {{(XLEN-16){lane_h[15]}}, lane_h};
         LOAD_HU: data = {{(XLEN-16){1'b0}}, lane_h};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/wb_queue_stage.sv
// rtl/wb_queue_stage.sv - writeback source select, in-order result queue draining to the regfile,
// and youngest-match forwarding out of the pending entries.
module wb_queue_stage
   import wb_queue_stage_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  write_back_mux_selector     in_wb_mux,
   input  logic [XLEN-1:0]            in_alu_result,
   input  logic                       in_alu_result_valid,
   input  logic [XLEN-1:0]            in_mem_result,
   input  logic                       in_mem_result_valid,
   input  load_size_e                 in_load_size,
   input  logic [1:0]                 in_byte_offset,
   input  logic [XLEN-1:0]            in_immediate,
   input  logic [XLEN-1:0]            in_pc,
   input  logic [REG_ADDR_W-1:0]      in_rd,
   output logic                       rf_write_valid,
   input  logic                       rf_write_ready,
   output logic [REG_ADDR_W-1:0]      rf_write_addr,
   output logic [XLEN-1:0]            rf_write_data,
   input  logic [REG_ADDR_W-1:0]      fwd_rs1_addr,
   input  logic [REG_ADDR_W-1:0]      fwd_rs2_addr,
   output logic                       fwd_rs1_hit,
   output logic                       fwd_rs2_hit,
   output logic [XLEN-1:0]            fwd_rs1_data,
   output logic [XLEN-1:0]            fwd_rs2_data,
   output logic [$clog2(DEPTH):0]     queue_count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;
   logic [REG_ADDR_W-1:0] rd_q   [DEPTH];
   logic [REG_ADDR_W-1:0] rd_d   [DEPTH];
   logic [XLEN-1:0]       data_q [DEPTH];
   logic [XLEN-1:0]       data_d [DEPTH];

   logic [XLEN-1:0] load_data;
   logic [XLEN-1:0] sel_data;
   logic            sel_wen;
   logic            accept, enq, deq;
   logic [PW-1:0]   idx;

   wb_load_align #(.XLEN(XLEN)) u_load_align (
      .word        (in_mem_result),
      .load_size   (in_load_size),
      .byte_offset (in_byte_offset),
      .data        (load_data)
   );

   assign in_ready       = (count_q != CW'(DEPTH));
   assign rf_write_valid = (count_q != '0);
   assign rf_write_addr  = rf_write_valid ? rd_q[head_q]   : '0;
   assign rf_write_data  = rf_write_valid ? data_q[head_q] : '0;
   assign queue_count    = count_q;

   always_comb begin
      sel_data = '0;
      sel_wen  = 1'b0;
      case (in_wb_mux)
         READ_ALU_RESULT: begin sel_data = in_alu_result; sel_wen = in_alu_result_valid; end
         READ_MEM_RESULT: begin sel_data = load_data;     sel_wen = in_mem_result_valid; end
         READ_REGFILE:    begin sel_data = in_immediate;  sel_wen = 1'b1;                end
         READ_PC4:        begin sel_data = in_pc + XLEN'(4); sel_wen = 1'b1;             end
         default:         begin sel_data = '0;            sel_wen = 1'b0;                end
      endcase
   end

   // Dropped entries still complete the handshake so MEM never stalls on them.
   assign accept = in_valid & in_ready;
   assign enq    = accept & sel_wen & (in_rd != '0);
   assign deq    = rf_write_valid & rf_write_ready;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      rd_d    = rd_q;
      data_d  = data_q;
      if (enq) begin
         rd_d[tail_q]   = in_rd;
         data_d[tail_q] = sel_data;
         tail_d         = tail_q + PW'(1);
      end
      if (deq) head_d = head_q + PW'(1);
      case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Scan oldest to youngest so the last match, the youngest, wins.
   always_comb begin
      fwd_rs1_hit  = 1'b0;
      fwd_rs2_hit  = 1'b0;
      fwd_rs1_data = '0;
      fwd_rs2_data = '0;
      idx          = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PW'(i);
         if (CW'(i) < count_q) begin
            if (fwd_rs1_addr != '0 && rd_q[idx] == fwd_rs1_addr) begin
               fwd_rs1_hit  = 1'b1;
               fwd_rs1_data = data_q[idx];
            end
            if (fwd_rs2_addr != '0 && rd_q[idx] == fwd_rs2_addr) begin
               fwd_rs2_hit  = 1'b1;
               fwd_rs2_data = data_q[idx];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_wb_queue_stage.sv
// tb/tb_wb_queue_stage.sv - directed self-checking bench for wb_queue_stage
module tb_wb_queue_stage;
   import wb_queue_stage_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   in_valid;
   logic                   in_ready;
   write_back_mux_selector in_wb_mux;
   logic [31:0]            in_alu_result;
   logic                   in_alu_result_valid;
   logic [31:0]            in_mem_result;
   logic                   in_mem_result_valid;
   load_size_e             in_load_size;
   logic [1:0]             in_byte_offset;
   logic [31:0]            in_immediate;
   logic [31:0]            in_pc;
   logic [4:0]             in_rd;
   logic                   rf_write_valid;
   logic                   rf_write_ready;
   logic [4:0]             rf_write_addr;
   logic [31:0]            rf_write_data;
   logic [4:0]             fwd_rs1_addr, fwd_rs2_addr;
   logic                   fwd_rs1_hit, fwd_rs2_hit;
   logic [31:0]            fwd_rs1_data, fwd_rs2_data;
   logic [2:0]             queue_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   wb_queue_stage #(.XLEN(32), .DEPTH(4), .REG_ADDR_W(5)) dut (
      .clk                 (clk),
      .reset               (reset),
      .in_valid            (in_valid),
      .in_ready            (in_ready),
      .in_wb_mux           (in_wb_mux),
      .in_alu_result       (in_alu_result),
      .in_alu_result_valid (in_alu_result_valid),
      .in_mem_result       (in_mem_result),
      .in_mem_result_valid (in_mem_result_valid),
      .in_load_size        (in_load_size),
      .in_byte_offset      (in_byte_offset),
      .in_immediate        (in_immediate),
      .in_pc               (in_pc),
      .in_rd               (in_rd),
      .rf_write_valid      (rf_write_valid),
      .rf_write_ready      (rf_write_ready),
      .rf_write_addr       (rf_write_addr),
      .rf_write_data       (rf_write_data),
      .fwd_rs1_addr        (fwd_rs1_addr),
      .fwd_rs2_addr        (fwd_rs2_addr),
      .fwd_rs1_hit         (fwd_rs1_hit),
      .fwd_rs2_hit         (fwd_rs2_hit),
      .fwd_rs1_data        (fwd_rs1_data),
      .fwd_rs2_data        (fwd_rs2_data),
      .queue_count         (queue_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input write_back_mux_selector sel, input logic [31:0] val,
                       input load_size_e sz, input logic [1:0] off, input logic [4:0] rd);
      in_valid            = 1'b1;
      in_wb_mux           = sel;
      in_alu_result       = val;
      in_alu_result_valid = 1'b1;
      in_mem_result       = val;
      in_mem_result_valid = 1'b1;
      in_load_size        = sz;
      in_byte_offset      = off;
      in_immediate        = val;
      in_pc               = val;
      in_rd               = rd;
      step();
      in_valid = 1'b0;
   endtask

   task automatic pop();
      rf_write_ready = 1'b1;
      step();
      rf_write_ready = 1'b0;
   endtask

   task automatic head(input string tag, input logic [4:0] rd, input logic [31:0] data);
      check({tag, "_valid"}, 32'(rf_write_valid), 32'd1);
      check({tag, "_addr"},  32'(rf_write_addr),  32'(rd));
      check({tag, "_data"},  rf_write_data,       data);
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_wb_mux = READ_ALU_RESULT;
      in_alu_result = '0; in_alu_result_valid = 1'b0; in_mem_result = '0;
      in_mem_result_valid = 1'b0; in_load_size = LOAD_W; in_byte_offset = '0;
      in_immediate = '0; in_pc = '0; in_rd = '0; rf_write_ready = 1'b0;
      fwd_rs1_addr = '0; fwd_rs2_addr = '0;
      step(); step();
      check("rst_count", 32'(queue_count), 32'd0);
      check("rst_valid", 32'(rf_write_valid), 32'd0);
      check("rst_addr", 32'(rf_write_addr), 32'd0);
      check("rst_data", rf_write_data, 32'd0);
      check("rst_hit1", 32'(fwd_rs1_hit), 32'd0);
      check("rst_fdata1", fwd_rs1_data, 32'd0);
      reset = 1'b1;
      step();
      check("rel_ready", 32'(in_ready), 32'd1);

      // ALU entry with the regfile always ready
      rf_write_ready = 1'b1;
      push(READ_ALU_RESULT, 32'h0000_1234, LOAD_W, 2'd0, 5'd5);
      head("alu", 5'd5, 32'h0000_1234);
      check("alu_count1", 32'(queue_count), 32'd1);
      step();
      check("alu_count0", 32'(queue_count), 32'd0);
      check("alu_valid0", 32'(rf_write_valid), 32'd0);
      rf_write_ready = 1'b0;

      // Load alignment / extension
      push(READ_MEM_RESULT, 32'h0080_0000, LOAD_B, 2'd2, 5'd7);
      head("lb", 5'd7, 32'hFFFF_FF80);
      pop();
      push(READ_MEM_RESULT, 32'h0080_0000, LOAD_BU, 2'd2, 5'd7);
      head("lbu", 5'd7, 32'h0000_0080);
      pop();
      push(READ_MEM_RESULT, 32'h8001_0000, LOAD_H, 2'd2, 5'd7);
      head("lh", 5'd7, 32'hFFFF_8001);
      pop();
      push(READ_MEM_RESULT, 32'h8001_8002, LOAD_HU, 2'd1, 5'd8);
      head("lhu_off1", 5'd8, 32'h0000_8002);
      pop();
      push(READ_MEM_RESULT, 32'h8765_4321, LOAD_W, 2'd3, 5'd9);
      head("lw_off3", 5'd9, 32'h8765_4321);
      pop();
      check("ld_empty", 32'(queue_count), 32'd0);

      // Fill to DEPTH, fifth held until one ready pulse
      for (int i = 1; i <= 4; i++) push(READ_REGFILE, 32'h100 + 32'(i), LOAD_W, 2'd0, 5'(i));
      check("full_ready", 32'(in_ready), 32'd0);
      check("full_count", 32'(queue_count), 32'd4);
      in_valid = 1'b1; in_wb_mux = READ_REGFILE; in_immediate = 32'h105; in_rd = 5'd6;
      step();
      check("held_count", 32'(queue_count), 32'd4);
      head("full_head", 5'd1, 32'h101);
      rf_write_ready = 1'b1;
      step();
      rf_write_ready = 1'b0;
      check("deq_count", 32'(queue_count), 32'd3);
      check("deq_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("fifth_count", 32'(queue_count), 32'd4);
      head("order2", 5'd2, 32'h102); pop();
      head("order3", 5'd3, 32'h103); pop();
      head("order4", 5'd4, 32'h104); pop();
      head("order6", 5'd6, 32'h105); pop();
      check("drain_count", 32'(queue_count), 32'd0);

      // Youngest-match forwarding
      push(READ_ALU_RESULT, 32'hAAAA_0001, LOAD_W, 2'd0, 5'd3);
      push(READ_ALU_RESULT, 32'hBBBB_0002, LOAD_W, 2'd0, 5'd3);
      fwd_rs1_addr = 5'd3; fwd_rs2_addr = 5'd0;
      #1;
      check("fwd1_hit", 32'(fwd_rs1_hit), 32'd1);
      check("fwd1_data", fwd_rs1_data, 32'hBBBB_0002);
      check("fwd2_r0_hit", 32'(fwd_rs2_hit), 32'd0);
      fwd_rs2_addr = 5'd4;
      #1;
      check("fwd2_miss", 32'(fwd_rs2_hit), 32'd0);
      pop();
      check("fwd1_after_pop", fwd_rs1_data, 32'hBBBB_0002);
      pop();
      check("fwd1_empty", 32'(fwd_rs1_hit), 32'd0);
      fwd_rs1_addr = 5'd0; fwd_rs2_addr = 5'd0;

      // PC+4 wrap and dropped entries
      push(READ_PC4, 32'hFFFF_FFFC, LOAD_W, 2'd0, 5'd10);
      head("pc4", 5'd10, 32'h0000_0000);
      pop();
      push(READ_ALU_RESULT, 32'h1111_1111, LOAD_W, 2'd0, 5'd0);
      check("rd0_count", 32'(queue_count), 32'd0);
      check("rd0_ready", 32'(in_ready), 32'd1);
      push(NO_WRITE_BACK, 32'h2222_2222, LOAD_W, 2'd0, 5'd11);
      check("nowb_count", 32'(queue_count), 32'd0);
      in_alu_result_valid = 1'b0;
      in_valid = 1'b1; in_wb_mux = READ_ALU_RESULT; in_rd = 5'd12;
      step();
      in_valid = 1'b0;
      check("alu_inv_count", 32'(queue_count), 32'd0);

      // Reset mid-operation
      for (int i = 0; i < 3; i++) push(READ_REGFILE, 32'h300 + 32'(i), LOAD_W, 2'd0, 5'(20 + i));
      check("pre_rst_count", 32'(queue_count), 32'd3);
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("mid_rst_count", 32'(queue_count), 32'd0);
      check("mid_rst_valid", 32'(rf_write_valid), 32'd0);
      rf_write_ready = 1'b1;
      step(); step();
      check("post_rst_valid", 32'(rf_write_valid), 32'd0);
      check("post_rst_count", 32'(queue_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
